// File: rtl/flag_branch_unit.sv
// EX-stage back end: EX/MEM result latch, status flags {C,V,LT,EQ,GT} and
// branch resolution with a fixed-length squash window after a taken branch.
module flag_branch_unit #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             stall_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    input  logic             carry_out,
    input  logic             overflow,
    input  logic             set_flags,
    input  logic             reg_write_in,
    input  logic [2:0]       dest_in,
    input  logic             br_en,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_target,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_result,
    output logic [2:0]       ex_dest,
    output logic             ex_reg_write,
    output logic [4:0]       flags,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_target,
    output logic             flush
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_ex_valid;
    logic [WIDTH-1:0] r_ex_result;
    logic [2:0]       r_ex_dest;
    logic             r_ex_reg_write;
    logic [4:0]       r_flags;
    logic             r_pc_load;
    logic [WIDTH-1:0] r_pc_target;
    logic             r_flush;

    logic w_accept;
    logic w_cond_true;
    logic w_taken;

    // Condition is judged on the flags as they stood before this instruction.
    always_comb begin
        w_cond_true = 1'b0;
        case (br_cond)
            3'd0:    w_cond_true = 1'b1;
            3'd1:    w_cond_true = r_flags[1];
            3'd2:    w_cond_true = ~r_flags[1];
            3'd3:    w_cond_true = r_flags[2];
            3'd4:    w_cond_true = r_flags[0];
            3'd5:    w_cond_true = r_flags[2] | r_flags[1];
            3'd6:    w_cond_true = r_flags[0] | r_flags[1];
            default: w_cond_true = r_flags[4];
        endcase
    end

    assign w_accept = valid_in & ~stall_in & (r_state == RUN);
    assign w_taken  = w_accept & br_en & w_cond_true;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_cnt          <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_result    <= '0;
            r_ex_dest      <= '0;
            r_ex_reg_write <= 1'b0;
            r_flags        <= '0;
            r_pc_load      <= 1'b0;
            r_pc_target    <= '0;
            r_flush        <= 1'b0;
        end else begin
            // pc_load is a strict one-cycle pulse, even across a stall.
            r_pc_load <= 1'b0;
            if (!stall_in) begin
                r_ex_valid <= w_accept;
                if (w_accept) begin
                    r_ex_result    <= alu_out;
                    r_ex_dest      <= dest_in;
                    r_ex_reg_write <= reg_write_in;
                    if (set_flags)
                        r_flags <= {carry_out, overflow, lt, eq, gt};
                end else begin
                    r_ex_reg_write <= 1'b0;
                end

                case (r_state)
                    RUN: begin
                        if (w_taken) begin
                            r_pc_load   <= 1'b1;
                            r_pc_target <= br_target;
                            r_flush     <= 1'b1;
                            r_cnt       <= 3'(FLUSH_CYCLES - 1);
                            r_state     <= FLUSH;
                        end
                    end
                    default: begin
                        if (r_cnt == 3'd0) begin
                            r_state <= RUN;
                            r_flush <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_result    = r_ex_result;
    assign ex_dest      = r_ex_dest;
    assign ex_reg_write = r_ex_reg_write;
    assign flags        = r_flags;
    assign pc_load      = r_pc_load;
    assign pc_target    = r_pc_target;
    assign flush        = r_flush;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios plus random traffic, all
// compared each cycle against a cycle-level behavioural model.
module tb_flag_branch_unit;
    localparam int W  = 16;
    localparam int FC = 2;

    logic         clk = 1'b0;
    logic         rst_n, valid_in, stall_in;
    logic [W-1:0] alu_out, br_target;
    logic         lt, eq, gt, carry_out, overflow, set_flags, reg_write_in, br_en;
    logic [2:0]   dest_in, br_cond;
    logic         ex_valid, ex_reg_write, pc_load, flush;
    logic [W-1:0] ex_result, pc_target;
    logic [2:0]   ex_dest;
    logic [4:0]   flags;

    always #5 clk = ~clk;

    flag_branch_unit #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall_in(stall_in),
        .alu_out(alu_out), .lt(lt), .eq(eq), .gt(gt), .carry_out(carry_out),
        .overflow(overflow), .set_flags(set_flags), .reg_write_in(reg_write_in),
        .dest_in(dest_in), .br_en(br_en), .br_cond(br_cond), .br_target(br_target),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .flags(flags), .pc_load(pc_load),
        .pc_target(pc_target), .flush(flush)
    );

    // Reference state: squash window tracked as "cycles of squash remaining".
    logic         m_ex_valid, m_ex_rw, m_pc_load;
    logic [W-1:0] m_ex_result, m_pc_target;
    logic [2:0]   m_ex_dest;
    logic [4:0]   m_flags;
    int           m_flush_left;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [2:0] c, input logic [4:0] f);
        bit cf = f[4], ltf = f[2], eqf = f[1], gtf = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return eqf;
            3'd2: return !eqf;
            3'd3: return ltf;
            3'd4: return gtf;
            3'd5: return ltf || eqf;
            3'd6: return gtf || eqf;
            default: return cf;
        endcase
    endfunction

    task automatic model_edge();
        bit acc, taken;
        if (!rst_n) begin
            m_ex_valid = 0; m_ex_rw = 0; m_pc_load = 0; m_ex_result = '0;
            m_pc_target = '0; m_ex_dest = '0; m_flags = '0; m_flush_left = 0;
        end else begin
            m_pc_load = 0;
            if (!stall_in) begin
                acc   = valid_in && (m_flush_left == 0);
                taken = acc && br_en && cond_ok(br_cond, m_flags);
                if (m_flush_left > 0) m_flush_left--;
                m_ex_valid = acc;
                if (acc) begin
                    m_ex_result = alu_out;
                    m_ex_dest   = dest_in;
                    m_ex_rw     = reg_write_in;
                    if (set_flags) m_flags = {carry_out, overflow, lt, eq, gt};
                end else begin
                    m_ex_rw = 0;
                end
                if (taken) begin
                    m_pc_load    = 1;
                    m_pc_target  = br_target;
                    m_flush_left = FC;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_ex_rw));
        chk("flags", 32'(flags), 32'(m_flags));
        chk("pc_load", 32'(pc_load), 32'(m_pc_load));
        chk("pc_target", 32'(pc_target), 32'(m_pc_target));
        chk("flush", 32'(flush), 32'(m_flush_left > 0));
        if (m_ex_valid) begin
            chk("ex_result", 32'(ex_result), 32'(m_ex_result));
            chk("ex_dest", 32'(ex_dest), 32'(m_ex_dest));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        valid_in = 0; stall_in = 0; alu_out = '0; lt = 0; eq = 0; gt = 0;
        carry_out = 0; overflow = 0; set_flags = 0; reg_write_in = 0;
        dest_in = '0; br_en = 0; br_cond = '0; br_target = '0;
    endtask

    task automatic randomize_inputs();
        valid_in     = $urandom_range(0, 3) != 0;
        stall_in     = $urandom_range(0, 3) == 0;
        alu_out      = W'($urandom);
        {lt, eq, gt} = 3'($urandom);
        carry_out    = 1'($urandom);
        overflow     = 1'($urandom);
        set_flags    = 1'($urandom);
        reg_write_in = 1'($urandom);
        dest_in      = 3'($urandom);
        br_en        = $urandom_range(0, 3) == 0;
        br_cond      = 3'($urandom);
        br_target    = W'($urandom);
        rst_n        = $urandom_range(0, 63) != 0;
    endtask

    initial begin
        idle();
        m_flush_left = 0;
        // Reset with a valid instruction presented
        rst_n = 0; valid_in = 1; alu_out = 16'h1234; reg_write_in = 1;
        cyc(); cyc();
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);

        // SUB sets LT
        rst_n = 1; idle(); valid_in = 1; alu_out = 16'hFE0C; lt = 1;
        set_flags = 1; reg_write_in = 1; dest_in = 3'd3;
        cyc();
        chk("sub_valid", 32'(ex_valid), 32'h1);
        chk("sub_result", 32'(ex_result), 32'hFE0C);
        chk("sub_flags", 32'(flags), 32'h04);

        // OR without flag update
        idle(); valid_in = 1; alu_out = 16'h00FF; gt = 1; reg_write_in = 1;
        cyc();
        chk("or_flags", 32'(flags), 32'h04);

        // Taken BLT, then three younger instructions
        idle(); valid_in = 1; br_en = 1; br_cond = 3'd3; br_target = 16'h0040;
        cyc();
        chk("blt_pc_load", 32'(pc_load), 32'h1);
        chk("blt_target", 32'(pc_target), 32'h0040);
        chk("blt_flush", 32'(flush), 32'h1);
        idle(); valid_in = 1; set_flags = 1; carry_out = 1; alu_out = 16'hAAAA;
        cyc();
        chk("sq1_valid", 32'(ex_valid), 32'h0);
        chk("sq1_pc_load", 32'(pc_load), 32'h0);
        chk("sq1_flags", 32'(flags), 32'h04);
        cyc();
        chk("sq2_valid", 32'(ex_valid), 32'h0);
        idle(); valid_in = 1; alu_out = 16'h5555; dest_in = 3'd5;
        cyc();
        chk("third_valid", 32'(ex_valid), 32'h1);
        chk("third_result", 32'(ex_result), 32'h5555);

        // BEQ with set_flags: judged on old EQ=0, flags still update
        idle(); valid_in = 1; br_en = 1; br_cond = 3'd1; set_flags = 1; eq = 1;
        br_target = 16'h0080;
        cyc();
        chk("beq_pc_load", 32'(pc_load), 32'h0);
        chk("beq_flush", 32'(flush), 32'h0);
        chk("beq_flags", 32'(flags), 32'h02);

        // Taken branch then stall for 3 cycles mid-flush
        idle(); valid_in = 1; br_en = 1; br_cond = 3'd0; br_target = 16'h0100;
        cyc();
        idle(); valid_in = 1; stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_flush", 32'(flush), 32'h1);
            chk("stall_pc_load", 32'(pc_load), 32'h0);
        end
        stall_in = 0;
        cyc();
        chk("post_stall_flush1", 32'(flush), 32'h1);
        cyc();
        chk("post_stall_flush2", 32'(flush), 32'h0);

        // Reset in the middle of a flush
        idle(); valid_in = 1; br_en = 1; br_cond = 3'd0; br_target = 16'h0200;
        cyc();
        idle(); rst_n = 0; valid_in = 1;
        cyc();
        chk("rst_mid_flush", 32'(flush), 32'h0);
        chk("rst_mid_ex_valid", 32'(ex_valid), 32'h0);
        rst_n = 1;
        cyc();
        chk("rst_mid_accept", 32'(ex_valid), 32'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
